bus_grant_arbiter: RTL and testbench
====================================

// Module: bus_grant_arbiter
// PURPOSE
//   Round-robin arbiter for the shared 32-source internal bus. Takes a request
//   vector from up to 32 bus drivers and grants the bus to exactly one of them.
//   It outputs a one-hot grant plus the matching 5-bit encoded select for the
//   bus multiplexer. Ownership is held until the owner signals done.
// PARAMETERS
//   N_SRC     32   number of requesters; fixed at 32 for this bus
//   SEL_W     5    width of the encoded select, log2(N_SRC)
//   HOLD_MAX  15   max cycles one owner may hold the bus; used only with BUS_ARB_TIMEOUT_EN
// PORTS
//   clk        in   1      system clock; all logic on posedge
//   clear      in   1      synchronous, active-high reset
//   req        in   32     request vector; bit k high = source k wants the bus
//   done       in   1      current owner has finished its transfer (1-cycle pulse)
//   grant      out  32     registered one-hot grant; all zero when the bus is free
//   bus_sel    out  5      encoded index of the current owner; 0 when bus_valid=0
//   bus_valid  out  1      high while some source owns the bus
//   timeout    out  1      forced-release pulse (present only with BUS_ARB_TIMEOUT_EN)
// BEHAVIOUR
//   - Reset (clear=1 at posedge):
//       grant=0, bus_sel=0, bus_valid=0, timeout=0, rr_ptr=0, state=IDLE.
//     Reset takes priority over all other inputs, including in mid-ownership.
//   - States: IDLE (bus free) and OWN (grant held).
//   - IDLE, req==0: remain in IDLE; outputs stay zero.
//   - IDLE, req!=0: winner = first set bit of req, scanning upward from rr_ptr
//     and wrapping 31->0. At the next edge:
//       grant <= 1<<winner, bus_sel <= winner, bus_valid <= 1, state <= OWN.
//     Latency from req to grant is one cycle.
//   - OWN: grant, bus_sel and bus_valid are frozen. Changes on req are ignored,
//     including the owner dropping its own request. Only done releases the bus.
//   - OWN with done=1 at an edge, the next edge applies:
//       grant <= 0, bus_sel <= 0, bus_valid <= 0,
//       rr_ptr <= owner+1 (mod 32; 31 wraps to 0), state <= IDLE.
//   - The mandatory single free cycle after release is the bus turnaround. The
//     next grant appears 2 edges after done at the earliest.
//   - done is ignored in IDLE.
//   - Invariant every cycle: grant == (bus_valid ? 1<<bus_sel : 0). grant never
//     has more than one bit set.
//   - rr_ptr is internal and 5-bit. It updates only on release or clear.
// CONFIGURATION
//   BUS_ARB_TIMEOUT_EN defined:
//     - A 4-bit hold counter clears on entry to OWN and increments each cycle
//       in OWN.
//     - When the counter reaches HOLD_MAX without done, the bus is released
//       exactly as if done were asserted.
//     - timeout pulses high for the one cycle in which grant drops.
//     - done and timeout hitting the same cycle count as a normal release;
//       timeout stays 0.
//   BUS_ARB_TIMEOUT_EN undefined:
//     - No counter and no timeout port; an owner may hold the bus indefinitely.
// TESTING
//   1. clear=1 for 2 cycles with req=32'hFFFF_FFFF
//        -> grant=0, bus_sel=0, bus_valid=0 throughout.
//   2. req=32'h0000_0010 after reset
//        -> next edge: grant=32'h10, bus_sel=4, bus_valid=1.
//      Hold 5 cycles, then pulse done
//        -> grant=0 next edge; re-granted to bit 4 one edge later.
//   3. req=32'h8000_0001 held constant, done 3 cycles after every grant
//        -> owner sequence 0, 31, 0, 31, with one idle cycle between owners.
//   4. Owner 31 releases with req=32'h8000_0004
//        -> rr_ptr wraps to 0; next grant=32'h4, bus_sel=2.
//   5. clear pulsed while bit 7 owns the bus, req=32'h0000_0180
//        -> outputs zero next edge; following grant is bit 7 (scan from rr_ptr=0).
//   6. BUS_ARB_TIMEOUT_EN, HOLD_MAX=15: grant bit 3, never assert done
//        -> grant drops after 15 cycles in OWN with a 1-cycle timeout pulse.
//      Repeat with done on the 15th cycle -> release with timeout=0.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin arbiter for the 32-source internal bus; the owner holds the bus until done.
// Define BUS_ARB_TIMEOUT_EN to add a HOLD_MAX-cycle forced release with a timeout pulse.
module bus_grant_arbiter #(
    parameter int N_SRC = 32,
    parameter int SEL_W = 5
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int HOLD_MAX = 15
`endif
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    input  logic             done,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_valid
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic             release_bus;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic       expire;
`endif

    // Round-robin scan: first requester at or above rr_ptr, wrapping through the top source.
    always_comb begin
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = rr_ptr_q + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        valid_d     = valid_q;
        rr_ptr_d    = rr_ptr_q;
        release_bus = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        expire      = (hold_cnt_q == 4'(HOLD_MAX - 1));
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d         = ST_OWN;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    sel_d           = winner;
                    valid_d         = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_d      = '0;
`endif
                end
            end
            default: begin
`ifdef BUS_ARB_TIMEOUT_EN
                hold_cnt_d  = hold_cnt_q + 4'd1;
                // A simultaneous done wins: that release is an ordinary one.
                timeout_d   = expire && !done;
                release_bus = done || expire;
`else
                release_bus = done;
`endif
                if (release_bus) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    sel_d    = '0;
                    valid_d  = 1'b0;
                    rr_ptr_d = sel_q + SEL_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            rr_ptr_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign bus_sel   = sel_q;
    assign bus_valid = valid_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Table-driven bench for bus_grant_arbiter: per-cycle vectors feed a scoreboard queue checked after each edge.
// Timeout vectors are included when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_grant_arbiter;

    logic        clk;
    logic        clear;
    logic [31:0] req;
    logic        done;
    logic [31:0] grant;
    logic [4:0]  bus_sel;
    logic        bus_valid;
`ifdef BUS_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    bus_grant_arbiter dut (
        .clk       (clk),
        .clear     (clear),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .bus_sel   (bus_sel),
        .bus_valid (bus_valid)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    typedef struct {
        logic        clr;
        logic [31:0] rq;
        logic        dn;
        logic [31:0] g;
        logic [4:0]  s;
        logic        v;
        logic        to;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] g;
        logic [4:0]  s;
        logic        v;
        logic        to;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic clr, input logic [31:0] rq, input logic dn,
                       input logic [31:0] g, input logic [4:0] s, input logic v,
                       input logic to);
        vec_t t;
        t.clr = clr; t.rq = rq; t.dn = dn;
        t.g = g; t.s = s; t.v = v; t.to = to;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // Scoreboard: outputs are compared just after the edge that sampled the matching vector.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", e.idx, grant, e.g);
            chk("bus_sel", e.idx, 32'(bus_sel), 32'(e.s));
            chk("bus_valid", e.idx, 32'(bus_valid), 32'(e.v));
`ifdef BUS_ARB_TIMEOUT_EN
            chk("timeout", e.idx, 32'(timeout), 32'(e.to));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        req   = '0;
        done  = 1'b0;

        // Reset held with every source requesting.
        add(1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 0);
        add(1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 0);
        // Single requester: grant, five held cycles with req churn, release, regrant.
        add(0, 32'h0000_0010, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0010, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0010, 0, 32'h10, 4, 1, 0);
        add(0, 32'hFFFF_FFFF, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0000, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0010, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0010, 1, 32'h0, 0, 0, 0);
        add(0, 32'h0000_0010, 0, 32'h10, 4, 1, 0);
        add(0, 32'h0000_0000, 1, 32'h0, 0, 0, 0);
        add(0, 32'h0000_0000, 1, 32'h0, 0, 0, 0);
        // Alternation between sources 0 and 31 from rr_ptr=0.
        add(1, 32'h8000_0001, 0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            add(0, 32'h8000_0001, 0, 32'h1, 0, 1, 0);
            add(0, 32'h8000_0001, 0, 32'h1, 0, 1, 0);
            add(0, 32'h8000_0001, 0, 32'h1, 0, 1, 0);
            add(0, 32'h8000_0001, 1, 32'h0, 0, 0, 0);
            add(0, 32'h8000_0001, 0, 32'h8000_0000, 31, 1, 0);
            add(0, 32'h8000_0001, 0, 32'h8000_0000, 31, 1, 0);
            add(0, 32'h8000_0001, 0, 32'h8000_0000, 31, 1, 0);
            if (k == 0) add(0, 32'h8000_0001, 1, 32'h0, 0, 0, 0);
        end
        // Owner 31 releases: rr_ptr wraps to 0, so bit 2 beats bit 31.
        add(0, 32'h8000_0004, 1, 32'h0, 0, 0, 0);
        add(0, 32'h8000_0004, 0, 32'h4, 2, 1, 0);
        add(0, 32'h0000_0000, 1, 32'h0, 0, 0, 0);
        // Park rr_ptr at 8, then clear mid-ownership: the rescan must restart at 0.
        add(0, 32'h0000_0080, 0, 32'h80, 7, 1, 0);
        add(0, 32'h0000_0000, 1, 32'h0, 0, 0, 0);
        add(0, 32'h0000_0080, 0, 32'h80, 7, 1, 0);
        add(0, 32'h0000_0180, 0, 32'h80, 7, 1, 0);
        add(1, 32'h0000_0180, 0, 32'h0, 0, 0, 0);
        add(0, 32'h0000_0180, 0, 32'h80, 7, 1, 0);
        add(0, 32'h0000_0180, 1, 32'h0, 0, 0, 0);
`ifdef BUS_ARB_TIMEOUT_EN
        // Forced release after 15 owned cycles, then done coinciding with the limit.
        add(1, 32'h0, 0, 32'h0, 0, 0, 0);
        add(0, 32'h8, 0, 32'h8, 3, 1, 0);
        for (int k = 0; k < 14; k++) add(0, 32'h8, 0, 32'h8, 3, 1, 0);
        add(0, 32'h0, 0, 32'h0, 0, 0, 1);
        add(0, 32'h0, 0, 32'h0, 0, 0, 0);
        add(0, 32'h8, 0, 32'h8, 3, 1, 0);
        for (int k = 0; k < 14; k++) add(0, 32'h8, 0, 32'h8, 3, 1, 0);
        add(0, 32'h0, 1, 32'h0, 0, 0, 0);
        add(0, 32'h0, 0, 32'h0, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            clear = vecs[i].clr;
            req   = vecs[i].rq;
            done  = vecs[i].dn;
            e.idx = i; e.g = vecs[i].g; e.s = vecs[i].s; e.v = vecs[i].v; e.to = vecs[i].to;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req  = '0;
        done = 1'b0;
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
